div_issue_ctrl: RTL and testbench

- EX-stage controller that issues DIV/DIVU instructions to the multi-cycle divider and drives its start/annul handshake.
- Holds the pipeline through the division and captures the 64-bit result.
- Produces a one-cycle HI/LO write: remainder to HI, quotient to LO.
- Sits between the ID/EX pipeline register and the divider; its HI/LO write port feeds the HI/LO register file.

---
 rtl/div_issue_ctrl_pkg.sv | 20 ++
 rtl/div_issue_ctrl.sv | 132 +++++++++++++
 tb/tb_div_issue_ctrl.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/div_issue_ctrl_pkg.sv
// Shared defines for the EX-stage divider issue controller: ALU codes,
// divider handshake levels, reset level and controller state encoding.
package div_issue_ctrl_pkg;

    localparam logic [4:0]  DIV_CONTROL  = 5'b11010;
    localparam logic [4:0]  DIVU_CONTROL = 5'b11011;

    localparam logic        DivStart     = 1'b1;
    localparam logic        DivStop      = 1'b0;

    localparam logic        RstEnable    = 1'b1;
    localparam logic [31:0] ZeroWord     = 32'h0000_0000;

    typedef enum logic [1:0] {
        DIVC_IDLE = 2'b00,
        DIVC_BUSY = 2'b01,
        DIVC_DONE = 2'b10
    } divc_state_e;

endpackage

// File: rtl/div_issue_ctrl.sv
// Issues DIV/DIVU to the multi-cycle divider, stalls EX until the result is
// ready, and emits a one-cycle HI/LO write (remainder->HI, quotient->LO).
module div_issue_ctrl
    import div_issue_ctrl_pkg::*;
#(
    parameter int OP_W   = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid_i,
    input  logic [OP_W-1:0]   ex_op_i,
    input  logic [DATA_W-1:0] ex_src_a_i,
    input  logic [DATA_W-1:0] ex_src_b_i,
    input  logic              ex_hold_i,
    input  logic              flush_i,
    input  logic              div_ready_i,
    input  logic [63:0]       div_result_i,
    output logic              div_start_o,
    output logic              div_annul_o,
    output logic [OP_W-1:0]   div_op_o,
    output logic [DATA_W-1:0] div_opa_o,
    output logic [DATA_W-1:0] div_opb_o,
    output logic              stall_req_o,
    output logic              hilo_we_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    localparam logic [OP_W-1:0] DIV_OP  = OP_W'(DIV_CONTROL);
    localparam logic [OP_W-1:0] DIVU_OP = OP_W'(DIVU_CONTROL);

    divc_state_e       state_q, state_d;
    logic              start_q, start_d;
    logic              annul_q, annul_d;
    logic              we_q, we_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [DATA_W-1:0] opa_q, opa_d;
    logic [DATA_W-1:0] opb_q, opb_d;
    logic [DATA_W-1:0] hi_q, hi_d;
    logic [DATA_W-1:0] lo_q, lo_d;
    logic              stall;
    logic              is_div;

    assign is_div = ex_valid_i & ((ex_op_i == DIV_OP) | (ex_op_i == DIVU_OP));

    always_comb begin
        state_d = state_q;
        start_d = start_q;
        annul_d = 1'b0;
        we_d    = 1'b0;
        op_d    = op_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        stall   = 1'b0;
        case (state_q)
            DIVC_IDLE: begin
                if (is_div && !flush_i) begin
                    op_d    = ex_op_i;
                    opa_d   = ex_src_a_i;
                    opb_d   = ex_src_b_i;
                    start_d = DivStart;
                    stall   = 1'b1;
                    state_d = DIVC_BUSY;
                end
            end
            DIVC_BUSY: begin
                stall = !div_ready_i;
                // A flush wins over a simultaneous ready: the result is dropped.
                if (flush_i) begin
                    annul_d = 1'b1;
                    start_d = DivStop;
                    state_d = DIVC_IDLE;
                end else if (div_ready_i) begin
                    hi_d    = div_result_i[DATA_W +: DATA_W];
                    lo_d    = div_result_i[0 +: DATA_W];
                    we_d    = 1'b1;
                    start_d = DivStop;
                    state_d = DIVC_DONE;
                end
            end
            DIVC_DONE: begin
                start_d = DivStop;
                if (ex_hold_i && !flush_i) begin
                    state_d = DIVC_DONE;
                end else begin
                    // A new division seen here is issued from IDLE next cycle.
                    stall   = is_div && !flush_i;
                    state_d = DIVC_IDLE;
                end
            end
            default: state_d = DIVC_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_q <= DIVC_IDLE;
            start_q <= DivStop;
            annul_q <= 1'b0;
            we_q    <= 1'b0;
            op_q    <= '0;
            opa_q   <= ZeroWord;
            opb_q   <= ZeroWord;
            hi_q    <= ZeroWord;
            lo_q    <= ZeroWord;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            annul_q <= annul_d;
            we_q    <= we_d;
            op_q    <= op_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign div_start_o = start_q;
    assign div_annul_o = annul_q;
    assign hilo_we_o   = we_q;
    assign div_op_o    = op_q;
    assign div_opa_o   = opa_q;
    assign div_opb_o   = opb_q;
    assign hi_o        = hi_q;
    assign lo_o        = lo_q;
    assign stall_req_o = stall;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Bench for div_issue_ctrl: a behavioural divider drives ready/result, and a
// transaction-level model predicts every output each cycle.
module tb_div_issue_ctrl;
    import div_issue_ctrl_pkg::*;

    localparam int OP_W   = 5;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              ex_valid_i = 1'b0;
    logic [OP_W-1:0]   ex_op_i = '0;
    logic [DATA_W-1:0] ex_src_a_i = '0;
    logic [DATA_W-1:0] ex_src_b_i = '0;
    logic              ex_hold_i = 1'b0;
    logic              flush_i = 1'b0;
    logic              div_ready_i = 1'b0;
    logic [63:0]       div_result_i = '0;
    logic              div_start_o, div_annul_o, stall_req_o, hilo_we_o;
    logic [OP_W-1:0]   div_op_o;
    logic [DATA_W-1:0] div_opa_o, div_opb_o, hi_o, lo_o;

    div_issue_ctrl #(.OP_W(OP_W), .DATA_W(DATA_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .ex_valid_i   (ex_valid_i),
        .ex_op_i      (ex_op_i),
        .ex_src_a_i   (ex_src_a_i),
        .ex_src_b_i   (ex_src_b_i),
        .ex_hold_i    (ex_hold_i),
        .flush_i      (flush_i),
        .div_ready_i  (div_ready_i),
        .div_result_i (div_result_i),
        .div_start_o  (div_start_o),
        .div_annul_o  (div_annul_o),
        .div_op_o     (div_op_o),
        .div_opa_o    (div_opa_o),
        .div_opb_o    (div_opb_o),
        .stall_req_o  (stall_req_o),
        .hilo_we_o    (hilo_we_o),
        .hi_o         (hi_o),
        .lo_o         (lo_o)
    );

    always #5 clk = ~clk;

    int vec_cnt = 0;
    int err_cnt = 0;

    // Transaction-level model: is a division outstanding, or has one finished
    // with its instruction still held in EX; plus the expected output values.
    bit          m_outstanding = 0;
    bit          m_held = 0;
    logic        e_start = 0, e_annul = 0, e_we = 0;
    logic [4:0]  e_op = '0;
    logic [31:0] e_a = '0, e_b = '0, e_hi = '0, e_lo = '0;
    int          completions = 0;
    int          we_pulses = 0;

    // Divider stand-in
    int dv_cnt = 0;
    int dv_lat = 35;
    bit dv_noise = 0;
    bit dv_rand_lat = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] ref_div(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'h0) return 64'h0;
        if (op == DIV_CONTROL) begin
            sa = {{32{a[31]}}, a};
            sb = {{32{b[31]}}, b};
        end else begin
            sa = {32'h0, a};
            sb = {32'h0, b};
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic cyc(input logic v, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic hold, input logic flush, input logic r);
        logic isdiv, exp_stall;
        @(negedge clk);
        if (div_start_o) begin
            if (dv_cnt >= dv_lat) begin
                div_ready_i  = 1'b1;
                div_result_i = ref_div(div_op_o, div_opa_o, div_opb_o);
            end else begin
                dv_cnt++;
                div_ready_i = 1'b0;
            end
        end else begin
            dv_cnt = 0;
            if (dv_rand_lat) dv_lat = $urandom_range(0, 12);
            div_ready_i  = dv_noise && ($urandom_range(0, 7) == 0);
            div_result_i = {$urandom, $urandom};
        end
        ex_valid_i = v;  ex_op_i = op;  ex_src_a_i = a;  ex_src_b_i = b;
        ex_hold_i = hold;  flush_i = flush;  rst = r;
        #1;
        isdiv = v && (op == DIV_CONTROL || op == DIVU_CONTROL);
        if (m_outstanding)               exp_stall = !div_ready_i;
        else if (m_held && hold && !flush) exp_stall = 1'b0;
        else                             exp_stall = isdiv && !flush;
        chk("stall_req", stall_req_o, exp_stall);

        e_annul = 0;
        e_we    = 0;
        if (r) begin
            m_outstanding = 0;  m_held = 0;
            e_start = 0;  e_op = '0;  e_a = '0;  e_b = '0;  e_hi = '0;  e_lo = '0;
        end else if (m_outstanding) begin
            if (flush) begin
                e_annul = 1;  e_start = 0;  m_outstanding = 0;
            end else if (div_ready_i) begin
                {e_hi, e_lo} = ref_div(e_op, e_a, e_b);
                e_we = 1;  e_start = 0;  m_outstanding = 0;  m_held = 1;
                completions++;
            end
        end else if (m_held) begin
            m_held = hold && !flush;
        end else if (isdiv && !flush) begin
            e_op = op;  e_a = a;  e_b = b;  e_start = 1;  m_outstanding = 1;
        end

        @(posedge clk);
        #1;
        we_pulses += int'(hilo_we_o);
        chk("div_start", div_start_o, e_start);
        chk("div_annul", div_annul_o, e_annul);
        chk("hilo_we",   hilo_we_o,   e_we);
        chk("div_op",    div_op_o,    e_op);
        chk("div_opa",   div_opa_o,   e_a);
        chk("div_opb",   div_opb_o,   e_b);
        chk("hi",        hi_o,        e_hi);
        chk("lo",        lo_o,        e_lo);
    endtask

    task automatic run_div(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input int hold_n);
        int c0 = completions;
        int guard = 0;
        while (completions == c0 && guard < 100) begin
            cyc(1'b1, op, a, b, hold_n > 0, 1'b0, 1'b0);
            guard++;
        end
        if (completions == c0) begin
            vec_cnt++;
            err_cnt++;
            $display("FAIL run_div_timeout: no completion after %0d cycles, expected one", guard);
        end
        for (int i = 0; i < hold_n; i++) cyc(1'b1, op, a, b, 1'b1, 1'b0, 1'b0);
    endtask

    typedef struct {
        logic       v;
        logic [4:0] op;
        logic       flush;
        logic       exp_stall;
    } dec_vec_t;

    initial begin
        dec_vec_t tbl[7];
        int p0;

        tbl[0] = '{1'b1, DIV_CONTROL,  1'b0, 1'b1};
        tbl[1] = '{1'b1, DIVU_CONTROL, 1'b0, 1'b1};
        tbl[2] = '{1'b0, DIV_CONTROL,  1'b0, 1'b0};
        tbl[3] = '{1'b1, 5'b11000,     1'b0, 1'b0};
        tbl[4] = '{1'b1, 5'b01010,     1'b0, 1'b0};
        tbl[5] = '{1'b1, DIVU_CONTROL, 1'b1, 1'b0};
        tbl[6] = '{1'b0, 5'b00000,     1'b0, 1'b0};

        // Reset state
        for (int i = 0; i < 3; i++) cyc(1'b1, DIV_CONTROL, 32'd1, 32'd1, 1'b0, 1'b0, 1'b1);

        // Issue decode, evaluated combinationally from IDLE while reset holds
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            div_ready_i = 1'b0;
            ex_valid_i = tbl[i].v;  ex_op_i = tbl[i].op;  flush_i = tbl[i].flush;
            ex_src_a_i = 32'd77;  ex_src_b_i = 32'd3;  rst = 1'b1;
            #1;
            chk($sformatf("decode_stall[%0d]", i), stall_req_o, tbl[i].exp_stall);
            @(posedge clk);
            #1;
            chk($sformatf("decode_start_in_rst[%0d]", i), div_start_o, 1'b0);
        end
        cyc(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);

        // DIVU 100 / 7
        dv_lat = 35;
        p0 = we_pulses;
        cyc(1'b1, DIVU_CONTROL, 32'd100, 32'd7, 1'b0, 1'b0, 1'b0);
        chk("divu100_start_rise", div_start_o, 1'b1);
        run_div(DIVU_CONTROL, 32'd100, 32'd7, 0);
        chk("divu100_hi", hi_o, 32'd2);
        chk("divu100_lo", lo_o, 32'd14);
        cyc(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        chk("divu100_start_fall", div_start_o, 1'b0);
        chk("divu100_pulses", we_pulses - p0, 1);

        // DIV -7 / 2
        run_div(DIV_CONTROL, 32'hFFFF_FFF9, 32'd2, 0);
        chk("div_neg_hi", hi_o, 32'hFFFF_FFFF);
        chk("div_neg_lo", lo_o, 32'hFFFF_FFFD);
        cyc(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);

        // DIV 5 / 0
        p0 = we_pulses;
        run_div(DIV_CONTROL, 32'd5, 32'd0, 0);
        chk("divzero_hi", hi_o, 32'd0);
        chk("divzero_lo", lo_o, 32'd0);
        cyc(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        chk("divzero_pulses", we_pulses - p0, 1);

        // Flush 10 cycles into BUSY, then DIVU 9 / 3
        p0 = we_pulses;
        cyc(1'b1, DIVU_CONTROL, 32'd1000, 32'd3, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) cyc(1'b1, DIVU_CONTROL, 32'd1000, 32'd3, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, DIVU_CONTROL, 32'd1000, 32'd3, 1'b0, 1'b1, 1'b0);
        chk("flush_annul", div_annul_o, 1'b1);
        chk("flush_start_drop", div_start_o, 1'b0);
        cyc(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        chk("flush_annul_once", div_annul_o, 1'b0);
        chk("flush_no_write", we_pulses - p0, 0);
        run_div(DIVU_CONTROL, 32'd9, 32'd3, 0);
        chk("after_flush_lo", lo_o, 32'd3);
        chk("after_flush_hi", hi_o, 32'd0);
        cyc(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);

        // Ready under ex_hold for 3 cycles, then back-to-back DIVU
        p0 = we_pulses;
        run_div(DIVU_CONTROL, 32'd20, 32'd6, 2);
        chk("hold_no_reissue", div_start_o, 1'b0);
        chk("hold_pulses", we_pulses - p0, 1);
        run_div(DIVU_CONTROL, 32'd8, 32'd2, 0);
        chk("b2b1_lo", lo_o, 32'd4);
        chk("b2b1_hi", hi_o, 32'd0);
        run_div(DIVU_CONTROL, 32'd9, 32'd4, 0);
        chk("b2b2_lo", lo_o, 32'd2);
        chk("b2b2_hi", hi_o, 32'd1);
        cyc(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);

        // Reset mid-BUSY
        p0 = we_pulses;
        for (int i = 0; i < 6; i++) cyc(1'b1, DIV_CONTROL, 32'd50, 32'd5, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, DIV_CONTROL, 32'd50, 32'd5, 1'b0, 1'b0, 1'b1);
        chk("rst_start", div_start_o, 1'b0);
        chk("rst_opa", div_opa_o, 32'd0);
        chk("rst_hi", hi_o, 32'd0);
        chk("rst_lo", lo_o, 32'd0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        chk("rst_no_write", we_pulses - p0, 0);

        // Random traffic against the model
        dv_noise = 1;
        dv_rand_lat = 1;
        for (int i = 0; i < 2000; i++) begin
            logic [4:0]  op;
            logic [31:0] b;
            int sel;
            sel = $urandom_range(0, 3);
            op  = (sel == 0) ? DIV_CONTROL : (sel == 1) ? DIVU_CONTROL : 5'($urandom);
            b   = ($urandom_range(0, 7) == 0) ? 32'd0 :
                  ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(1, 20));
            cyc($urandom_range(0, 3) != 0, op, $urandom, b,
                $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 63) == 0);
        end
        chk("pulses_vs_completions", we_pulses, completions);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
